// File: rtl/mtx_addrgen_if.sv
`default_nettype none
// ============================================================================
// Module      : mtx_addrgen_if
// Description : Bus bundle between the GPU/sequencer side and the matrix
//               element address generator.
// Revision    : 1.0  initial release
// ============================================================================
interface mtx_addrgen_if #(
    parameter int AW = 10
);
    logic [31:0]   gpu_din;
    logic          mtxawr;
    logic          mtxcwr;
    logic          mmult;
    logic          mtx_mreq;
    logic          datack;
    logic [AW-1:0] mtxaddr;
    logic          mtx_rd;
    logic          mtx_dvalid;
    logic          mtx_busy;
    logic          mtx_done;
    logic [4:0]    remain;

    // Driver side: GPU register writes, sequencer requests, memory acks
    modport master (
        output gpu_din, mtxawr, mtxcwr, mmult, mtx_mreq, datack,
        input  mtxaddr, mtx_rd, mtx_dvalid, mtx_busy, mtx_done, remain
    );

    // Address generator side
    modport slave (
        input  gpu_din, mtxawr, mtxcwr, mmult, mtx_mreq, datack,
        output mtxaddr, mtx_rd, mtx_dvalid, mtx_busy, mtx_done, remain
    );
endinterface
`default_nettype wire

// File: rtl/mtx_addrgen.sv
`default_nettype none
// ============================================================================
// Module      : mtx_addrgen
// Description : Matrix element address generator. Walks a row (stride 1) or
//               column (stride N) of a matrix in local RAM, one element per
//               request, issuing a read strobe and waiting for the memory ack.
// Revision    : 1.0  initial release
// ============================================================================
module mtx_addrgen #(
    parameter int AW = 10
) (
    input  wire logic     clk,
    input  wire logic     reset,
    mtx_addrgen_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]    r_state;
    logic [AW-1:0] r_base;
    logic [AW-1:0] r_ptr;
    logic [3:0]    r_mwidth;
    logic          r_maddw;
    logic [4:0]    r_remain;
    logic          r_rd;
    logic          r_done;

    logic [4:0]    w_len;
    logic [AW-1:0] w_step;
    logic [AW-1:0] w_gpu_addr;
    logic [4:0]    w_remain_dec;
    logic          w_ack;
    logic          w_unused;

    // A programmed width of 0 means a full 16-element vector
    assign w_len        = (r_mwidth == 4'd0) ? 5'd16 : {1'b0, r_mwidth};
    // Column mode jumps a whole row per element; row mode walks adjacent words
    assign w_step       = r_maddw ? {{(AW-5){1'b0}}, w_len} : {{(AW-1){1'b0}}, 1'b1};
    assign w_gpu_addr   = bus.gpu_din[AW+1:2];
    assign w_remain_dec = (r_remain != 5'd0) ? (r_remain - 5'd1) : 5'd0;
    // Memory ack only counts while an element read is outstanding
    assign w_ack        = (r_state == S_WAIT) && bus.datack;
    assign w_unused     = ^{bus.gpu_din[31:AW+2], bus.gpu_din[1:0]};

    // Configuration registers, fetch sequencer and registered strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_base   <= '0;
            r_ptr    <= '0;
            r_mwidth <= 4'd0;
            r_maddw  <= 1'b0;
            r_remain <= 5'd0;
            r_rd     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_rd   <= 1'b0;
            r_done <= 1'b0;

            if (bus.mtxcwr) begin
                r_mwidth <= bus.gpu_din[3:0];
                r_maddw  <= bus.gpu_din[4];
            end
            if (bus.mtxawr) begin
                r_base <= w_gpu_addr;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.mmult) begin
                        r_remain <= w_len;
                        r_ptr    <= r_base;
                    end else if (bus.mtx_mreq && (r_remain != 5'd0)) begin
                        r_state <= S_ISSUE;
                        r_rd    <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.datack) begin
                        r_ptr    <= r_ptr + w_step;
                        r_remain <= w_remain_dec;
                        r_done   <= (r_remain == 5'd1);
                        if ((w_remain_dec != 5'd0) && bus.mtx_mreq) begin
                            r_state <= S_ISSUE;
                            r_rd    <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // A direct address write overrides any advance in the same cycle
            if (bus.mtxawr) begin
                r_ptr <= w_gpu_addr;
            end
        end
    end

    assign bus.mtxaddr    = r_ptr;
    assign bus.mtx_rd     = r_rd;
    assign bus.mtx_dvalid = w_ack;
    assign bus.mtx_done   = r_done;
    assign bus.remain     = r_remain;
    assign bus.mtx_busy   = (r_state != S_IDLE) || (r_remain != 5'd0);

endmodule
`default_nettype wire

// File: doc/mtx_addrgen.md
MTX_ADDRGEN -- requirements
Module: mtx_addrgen

Interface
REQ-001 Parameter AW, default 10, word-address width of the matrix pointer (byte address bits 11:2).
REQ-002 Port list; each entry gives name, direction, width and meaning:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- gpu_din  in  32  GPU write data bus.
- mtxawr  in  1  load matrix base address from gpu_din[11:2].
- mtxcwr  in  1  load control: width from gpu_din[3:0], column mode from gpu_din[4].
- mmult  in  1  one-cycle start pulse for a matrix multiply.
- mtx_mreq  in  1  element request from the systolic sequencer.
- datack  in  1  memory data acknowledge.
- mtxaddr  out  AW  current element word address.
- mtx_rd  out  1  one-cycle read strobe to local RAM.
- mtx_dvalid  out  1  element data accepted this cycle.
- mtx_busy  out  1  fetch sequence in progress.
- mtx_done  out  1  one-cycle pulse after the last element is acknowledged.
- remain  out  5  elements still to fetch.

Function
REQ-003 Registers:
- base: AW bits.
- ptr: AW bits, drives mtxaddr.
- mwidth: 4 bits.
- maddw: 1 bit.
- remain: 5 bits.
- state: IDLE, ISSUE, WAIT.
REQ-004 mtxcwr: mwidth <= gpu_din[3:0], maddw <= gpu_din[4], both on the next edge, in any state.
REQ-005 mtxawr: base <= gpu_din[11:2] and ptr <= gpu_din[11:2], in any state.
REQ-006 mtxawr has priority over any pointer advance in the same cycle.
REQ-007 Effective length N = mwidth, except mwidth = 0 gives N = 16.
REQ-008 mmult in IDLE: remain <= N, ptr <= base, state stays IDLE.
REQ-009 mmult outside IDLE is ignored.
REQ-010 Step size: maddw = 0 (row mode) steps ptr by 1. maddw = 1 (column mode) steps ptr by N.
REQ-011 Pointer arithmetic is modulo 2^AW; wrap-around is silent.
REQ-012 IDLE -> ISSUE when mtx_mreq = 1 and remain != 0.
REQ-013 mtx_mreq with remain = 0 is ignored.
REQ-014 ISSUE lasts exactly one cycle:
- mtx_rd = 1 and mtxaddr = ptr during that cycle;
- next state is WAIT.
REQ-015 WAIT holds ptr until datack = 1; the wait is unbounded.
REQ-016 On the datack cycle in WAIT:
- mtx_dvalid = 1 (combinational);
- ptr <= ptr + step;
- remain <= remain - 1.
REQ-017 After that datack, if the new remain != 0 and mtx_mreq = 1, next state is ISSUE (back-to-back, one element per two cycles).
REQ-018 Otherwise after that datack, next state is IDLE.
REQ-019 When remain goes 1 -> 0, mtx_done is registered high for exactly the next cycle.
REQ-020 datack outside WAIT is ignored: no dvalid, no pointer or count change.
REQ-021 remain never underflows; it saturates at 0.
REQ-022 mtx_busy = (state != IDLE) OR (remain != 0).
REQ-023 mtx_rd and mtx_dvalid are never both high in the same cycle.
REQ-024 mtxcwr mid-sequence changes the step from the next advance onward; remain is unaffected.

Reset
REQ-025 reset asserted forces state = IDLE with no clock edge required.
REQ-026 reset asserted also clears to 0: ptr, base, mwidth, maddw, remain, mtx_rd, mtx_dvalid, mtx_done, mtx_busy.
REQ-027 reset mid-sequence abandons the fetch; no mtx_done is produced.
REQ-028 After reset deasserts, the first rising edge operates normally.

Verification
REQ-029 Row fetch: mtxcwr with din = 0x04, mtxawr with din = 0x100, mmult, then hold mtx_mreq and answer each read with datack one cycle later.
- Required: mtxaddr = 0x40, 0x41, 0x42, 0x43 on the four mtx_rd strobes.
- Required: four mtx_dvalid pulses, then mtx_done one cycle after the fourth datack, remain = 0.
REQ-030 Column fetch with width 0: mtxcwr with din = 0x10 (N = 16, column mode), base 0x3F8.
- Required: addresses 0x3F8, 0x008, 0x018, and onward (mod 1024 wrap).
- Required: exactly 16 strobes.
REQ-031 Stalled acknowledge: hold datack low for 20 cycles in WAIT.
- Required: mtxaddr stable, no extra mtx_rd, mtx_busy = 1.
- Required: advance on the cycle datack rises.
REQ-032 Collisions:
- mtxawr in the same cycle as a datack: ptr takes the gpu_din value and remain still decrements.
- mmult while busy: no effect.
REQ-033 Reset mid-sequence: assert reset during WAIT with remain = 3.
- Required immediately: all outputs 0 and state IDLE.
- Required afterwards: a later mtx_mreq issues nothing until mmult.
REQ-034 Stray inputs in IDLE: datack and mtx_mreq with remain = 0 produce no mtx_rd, no mtx_dvalid and no mtx_done.
